// File: rtl/brc_arbiter.sv
// brc_arbiter: shares one branch comparator between branch and SLT requesters.
// Define BRC_ARB_RR_EN for round-robin ties; otherwise branch has fixed priority.
module brc_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_br_valid,
  output logic        o_br_ready,
  input  logic [31:0] i_br_rs1,
  input  logic [31:0] i_br_rs2,
  input  logic [2:0]  i_br_funct3,
  output logic        o_br_rsp_valid,
  input  logic        i_br_rsp_ready,
  output logic        o_br_taken,
  output logic        o_br_funct_err,
  input  logic        i_slt_valid,
  output logic        o_slt_ready,
  input  logic [31:0] i_slt_a,
  input  logic [31:0] i_slt_b,
  input  logic        i_slt_signed,
  output logic        o_slt_rsp_valid,
  input  logic        i_slt_rsp_ready,
  output logic [31:0] o_slt_result,
  output logic [31:0] o_cmp_rs1,
  output logic [31:0] o_cmp_rs2,
  output logic        o_cmp_un,
  input  logic        i_cmp_less,
  input  logic        i_cmp_equal
);

  logic br_free;
  logic slt_free;
  logic br_elig;
  logic slt_elig;
  logic grant_br;
  logic grant_slt;
  logic br_taken_d;
  logic br_err_d;

  // a held slot may drain and refill in the same cycle
  assign br_free  = ~o_br_rsp_valid | i_br_rsp_ready;
  assign slt_free = ~o_slt_rsp_valid | i_slt_rsp_ready;
  assign br_elig  = i_br_valid & br_free;
  assign slt_elig = i_slt_valid & slt_free;

`ifdef BRC_ARB_RR_EN
  logic last_slt;

  // reset as if slt went last so branch wins the first tie
  assign grant_br = br_elig & (~slt_elig | last_slt);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      last_slt <= 1'b1;
    else if (grant_br | grant_slt)
      last_slt <= grant_slt;
  end
`else
  assign grant_br = br_elig;
`endif

  assign grant_slt   = slt_elig & ~grant_br;
  assign o_br_ready  = grant_br;
  assign o_slt_ready = grant_slt;

  always_comb begin
    o_cmp_rs1 = '0;
    o_cmp_rs2 = '0;
    o_cmp_un  = 1'b0;
    unique case (1'b1)
      grant_br: begin
        o_cmp_rs1 = i_br_rs1;
        o_cmp_rs2 = i_br_rs2;
        o_cmp_un  = ~i_br_funct3[1];
      end
      grant_slt: begin
        o_cmp_rs1 = i_slt_a;
        o_cmp_rs2 = i_slt_b;
        o_cmp_un  = i_slt_signed;
      end
      default: ;
    endcase
  end

  always_comb begin
    br_taken_d = 1'b0;
    br_err_d   = 1'b0;
    unique case (i_br_funct3)
      3'b000:         br_taken_d = i_cmp_equal;
      3'b001:         br_taken_d = ~i_cmp_equal;
      3'b100, 3'b110: br_taken_d = i_cmp_less;
      3'b101, 3'b111: br_taken_d = ~i_cmp_less;
      default:        br_err_d   = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_br_rsp_valid <= 1'b0;
      o_br_taken     <= 1'b0;
      o_br_funct_err <= 1'b0;
    end else if (grant_br) begin
      o_br_rsp_valid <= 1'b1;
      o_br_taken     <= br_taken_d;
      o_br_funct_err <= br_err_d;
    end else if (i_br_rsp_ready) begin
      o_br_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_slt_rsp_valid <= 1'b0;
      o_slt_result    <= '0;
    end else if (grant_slt) begin
      o_slt_rsp_valid <= 1'b1;
      o_slt_result    <= {31'b0, i_cmp_less};
    end else if (i_slt_rsp_ready) begin
      o_slt_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_brc_arbiter.sv
// tb_brc_arbiter: vector table plus scoreboard for brc_arbiter.
// Comparator is modelled behaviourally from o_cmp_* in the bench.
module tb_brc_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_br_valid;
  logic        o_br_ready;
  logic [31:0] i_br_rs1;
  logic [31:0] i_br_rs2;
  logic [2:0]  i_br_funct3;
  logic        o_br_rsp_valid;
  logic        i_br_rsp_ready;
  logic        o_br_taken;
  logic        o_br_funct_err;
  logic        i_slt_valid;
  logic        o_slt_ready;
  logic [31:0] i_slt_a;
  logic [31:0] i_slt_b;
  logic        i_slt_signed;
  logic        o_slt_rsp_valid;
  logic        i_slt_rsp_ready;
  logic [31:0] o_slt_result;
  logic [31:0] o_cmp_rs1;
  logic [31:0] o_cmp_rs2;
  logic        o_cmp_un;
  logic        i_cmp_less;
  logic        i_cmp_equal;

  brc_arbiter dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_br_valid      (i_br_valid),
    .o_br_ready      (o_br_ready),
    .i_br_rs1        (i_br_rs1),
    .i_br_rs2        (i_br_rs2),
    .i_br_funct3     (i_br_funct3),
    .o_br_rsp_valid  (o_br_rsp_valid),
    .i_br_rsp_ready  (i_br_rsp_ready),
    .o_br_taken      (o_br_taken),
    .o_br_funct_err  (o_br_funct_err),
    .i_slt_valid     (i_slt_valid),
    .o_slt_ready     (o_slt_ready),
    .i_slt_a         (i_slt_a),
    .i_slt_b         (i_slt_b),
    .i_slt_signed    (i_slt_signed),
    .o_slt_rsp_valid (o_slt_rsp_valid),
    .i_slt_rsp_ready (i_slt_rsp_ready),
    .o_slt_result    (o_slt_result),
    .o_cmp_rs1       (o_cmp_rs1),
    .o_cmp_rs2       (o_cmp_rs2),
    .o_cmp_un        (o_cmp_un),
    .i_cmp_less      (i_cmp_less),
    .i_cmp_equal     (i_cmp_equal)
  );

  always #5 i_clk = ~i_clk;

  assign i_cmp_equal = (o_cmp_rs1 == o_cmp_rs2);
  assign i_cmp_less  = o_cmp_un ? ($signed(o_cmp_rs1) < $signed(o_cmp_rs2))
                                : (o_cmp_rs1 < o_cmp_rs2);

`ifdef BRC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic taken;
    logic err;
  } br_exp_t;

  typedef struct {
    logic        is_slt;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        exp_un;
    logic        exp_bit;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t        vecs[10];
  br_exp_t     br_q[$];
  logic [31:0] slt_q[$];
  br_exp_t     cur_br;
  logic [31:0] cur_slt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at negedge+1: score takes, record grants, advance to next negedge
  task automatic step();
    br_exp_t e;
    logic [31:0] s;
    if (o_br_rsp_valid && i_br_rsp_ready) begin
      chk("br_rsp_expected", 32'(br_q.size() != 0), 1);
      if (br_q.size() != 0) begin
        e = br_q.pop_front();
        chk("br_taken", o_br_taken, e.taken);
        chk("br_err", o_br_funct_err, e.err);
      end
    end
    if (o_slt_rsp_valid && i_slt_rsp_ready) begin
      chk("slt_rsp_expected", 32'(slt_q.size() != 0), 1);
      if (slt_q.size() != 0) begin
        s = slt_q.pop_front();
        chk("slt_result", o_slt_result, s);
      end
    end
    chk("one_grant", o_br_ready & o_slt_ready, 0);
    if (o_br_ready) br_q.push_back(cur_br);
    if (o_slt_ready) slt_q.push_back(cur_slt);
    @(negedge i_clk);
  endtask

  task automatic set_br(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic tk, input logic er);
    i_br_valid  = 1'b1;
    i_br_rs1    = a;
    i_br_rs2    = b;
    i_br_funct3 = f;
    cur_br      = '{taken: tk, err: er};
  endtask

  task automatic set_slt(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic r);
    i_slt_valid  = 1'b1;
    i_slt_a      = a;
    i_slt_b      = b;
    i_slt_signed = sg;
    cur_slt      = {31'b0, r};
  endtask

  task automatic drain();
    i_br_valid      = 1'b0;
    i_slt_valid     = 1'b0;
    i_br_rsp_ready  = 1'b1;
    i_slt_rsp_ready = 1'b1;
    #1 step();
    #1 step();
    chk("br_q_empty", br_q.size(), 0);
    chk("slt_q_empty", slt_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic exp_br;
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b100, 1'b1, 1'b1, 1'b0, "blt"};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b110, 1'b0, 1'b0, 1'b0, "bltu"};
    vecs[2] = '{1'b0, 32'h1234, 32'h1234, 3'b000, 1'b1, 1'b1, 1'b0, "beq"};
    vecs[3] = '{1'b0, 32'h1234, 32'h1234, 3'b010, 1'b0, 1'b0, 1'b1, "f010"};
    vecs[4] = '{1'b0, 32'h5, 32'h6, 3'b001, 1'b1, 1'b1, 1'b0, "bne"};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b101, 1'b1, 1'b0, 1'b0, "bge"};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b111, 1'b0, 1'b1, 1'b0, "bgeu"};
    vecs[7] = '{1'b1, 32'h0, 32'h80000000, 3'b000, 1'b0, 1'b1, 1'b0, "sltu"};
    vecs[8] = '{1'b1, 32'h0, 32'h80000000, 3'b001, 1'b1, 1'b0, 1'b0, "slt"};
    vecs[9] = '{1'b1, 32'hFFFFFFFE, 32'h3, 3'b001, 1'b1, 1'b1, 1'b0, "slt_neg"};

    i_reset         = 1'b1;
    i_br_valid      = 1'b0;
    i_br_rs1        = '0;
    i_br_rs2        = '0;
    i_br_funct3     = '0;
    i_br_rsp_ready  = 1'b1;
    i_slt_valid     = 1'b0;
    i_slt_a         = '0;
    i_slt_b         = '0;
    i_slt_signed    = 1'b0;
    i_slt_rsp_ready = 1'b1;
    cur_br          = '0;
    cur_slt         = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_br_rsp_valid", o_br_rsp_valid, 0);
    chk("rst_br_taken", o_br_taken, 0);
    chk("rst_br_err", o_br_funct_err, 0);
    chk("rst_slt_rsp_valid", o_slt_rsp_valid, 0);
    chk("rst_slt_result", o_slt_result, 0);
    i_reset = 1'b0;
    #1;
    chk("idle_cmp_rs1", o_cmp_rs1, 0);
    chk("idle_cmp_rs2", o_cmp_rs2, 0);
    chk("idle_cmp_un", o_cmp_un, 0);
    step();

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      if (v.is_slt) begin
        i_br_valid = 1'b0;
        set_slt(v.a, v.b, v.f[0], v.exp_bit);
      end else begin
        i_slt_valid = 1'b0;
        set_br(v.a, v.b, v.f, v.exp_bit, v.exp_err);
      end
      #1;
      chk({v.name, "_ready"}, v.is_slt ? o_slt_ready : o_br_ready, 1);
      chk({v.name, "_un"}, o_cmp_un, v.exp_un);
      chk({v.name, "_rs1"}, o_cmp_rs1, v.a);
      step();
      i_br_valid  = 1'b0;
      i_slt_valid = 1'b0;
      chk({v.name, "_rsp_valid"},
          v.is_slt ? o_slt_rsp_valid : o_br_rsp_valid, 1);
    end
    drain();

    // contention: both valid for four cycles
    set_br(32'h7, 32'h7, 3'b000, 1'b1, 1'b0);
    set_slt(32'h1, 32'h2, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_br = RR ? ((k % 2) == 0) : 1'b1;
      #1;
      chk($sformatf("tie%0d_br_ready", k), o_br_ready, exp_br);
      chk($sformatf("tie%0d_slt_ready", k), o_slt_ready, !exp_br);
      step();
    end
    drain();

    // branch backpressure while slt keeps flowing
    i_br_rsp_ready = 1'b0;
    set_br(32'hFFFFFFFF, 32'h1, 3'b100, 1'b1, 1'b0);
    #1;
    chk("bp_first_ready", o_br_ready, 1);
    step();
    set_br(32'h1, 32'h2, 3'b000, 1'b0, 1'b0);
    set_slt(32'h5, 32'h3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_br_ready", k), o_br_ready, 0);
      chk($sformatf("bp%0d_slt_ready", k), o_slt_ready, 1);
      chk($sformatf("bp%0d_br_taken", k), o_br_taken, 1);
      chk($sformatf("bp%0d_br_rsp_valid", k), o_br_rsp_valid, 1);
      step();
    end
    i_slt_valid    = 1'b0;
    i_br_rsp_ready = 1'b1;
    #1;
    chk("refill_br_ready", o_br_ready, 1);
    step();
    chk("refill_rsp_valid", o_br_rsp_valid, 1);
    chk("refill_taken", o_br_taken, 0);
    drain();

    // fill both slots, then reset asynchronously
    i_br_rsp_ready  = 1'b0;
    i_slt_rsp_ready = 1'b0;
    set_br(32'h7, 32'h7, 3'b000, 1'b1, 1'b0);
    set_slt(32'h1, 32'h2, 1'b0, 1'b1);
    #1 step();
    #1 step();
    i_br_valid  = 1'b0;
    i_slt_valid = 1'b0;
    #2;
    chk("pre_rst_br_valid", o_br_rsp_valid, 1);
    chk("pre_rst_slt_valid", o_slt_rsp_valid, 1);
    i_reset = 1'b1;
    #1;
    chk("async_rst_br_valid", o_br_rsp_valid, 0);
    chk("async_rst_slt_valid", o_slt_rsp_valid, 0);
    br_q.delete();
    slt_q.delete();
    @(negedge i_clk);
    i_reset         = 1'b0;
    i_br_rsp_ready  = 1'b1;
    i_slt_rsp_ready = 1'b1;
    set_br(32'h7, 32'h7, 3'b000, 1'b1, 1'b0);
    set_slt(32'h1, 32'h2, 1'b0, 1'b1);
    #1;
    chk("post_rst_br_ready", o_br_ready, 1);
    chk("post_rst_slt_ready", o_slt_ready, 0);
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
